// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths, load funct3 codes and writeback FSM states
package wb_stage_pkg;
    localparam int REG_BUS = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    typedef enum logic [1:0] {IDLE, LOAD_WAIT, DRAIN} wb_state_t;
endpackage

// File: rtl/wb_stage_load_formatter.sv
// load_formatter: selects and sign/zero-extends a sub-word from a little-endian memory word
module load_formatter
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = REG_BUS
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] data
);
    logic [DATA_W-1:0] byte_sh;
    logic [DATA_W-1:0] half_sh;
    logic [7:0]        b;
    logic [15:0]       h;
    assign byte_sh = rdata >> {addr_lo, 3'b000};
    assign half_sh = rdata >> {addr_lo[1], 4'b0000};
    assign b = byte_sh[7:0];
    assign h = half_sh[15:0];
    always_comb begin
        data = funct3 == F3_LB  ? {{(DATA_W-8){b[7]}}, b} :
               funct3 == F3_LH  ? {{(DATA_W-16){h[15]}}, h} :
               funct3 == F3_LW  ? rdata :
               funct3 == F3_LBU ? {{(DATA_W-8){1'b0}}, b} :
               funct3 == F3_LHU ? {{(DATA_W-16){1'b0}}, h} : '0;
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM->WB stage, registers ALU results and runs word-read loads with stall.
// Optional WB_MISALIGN_CHECK_EN: rejects misaligned LH/LHU/LW and pulses misalign_err.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W  = REG_BUS,
    parameter int RADDR_W = REG_ADDR_BUS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               in_valid,
    input  logic               in_we,
    input  logic [RADDR_W-1:0] in_waddr,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_is_load,
    input  logic [2:0]         in_funct3,
    input  logic               flush,
    output logic               stall_req,
    output logic               mem_req,
    output logic [DATA_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata,
`ifdef WB_MISALIGN_CHECK_EN
    output logic               misalign_err,
`endif
    output logic               wb_we,
    output logic [RADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0]  wb_wdata
);
    wb_state_t          state, next_state;
    logic               lat_we;
    logic [RADDR_W-1:0] lat_waddr;
    logic [2:0]         lat_funct3;
    logic [1:0]         lat_lo;
    logic [DATA_W-1:0]  fmt_data;
    logic               load_req, load_go;

    assign load_req = (state == IDLE) & in_valid & in_is_load & !flush;
`ifdef WB_MISALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = ((in_funct3 == F3_LH || in_funct3 == F3_LHU) & in_data[0]) |
                        ((in_funct3 == F3_LW) & |in_data[1:0]);
    assign load_go = load_req & !misaligned;
`else
    assign load_go = load_req;
`endif

    load_formatter #(.DATA_W(DATA_W)) u_fmt (
        .rdata(mem_rdata),
        .funct3(lat_funct3),
        .addr_lo(lat_lo),
        .data(fmt_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else if (rdy) state <= next_state;
    end

    always_comb begin
        next_state = state == IDLE      ? (load_go ? LOAD_WAIT : IDLE) :
                     state == LOAD_WAIT ? (mem_ack ? IDLE : flush ? DRAIN : LOAD_WAIT) :
                                          (mem_ack ? IDLE : DRAIN);
    end

    always_comb begin
        stall_req = load_go | (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we      <= 1'b0;
            wb_waddr   <= '0;
            wb_wdata   <= DATA_W'(ZERO_WORD);
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            lat_we     <= 1'b0;
            lat_waddr  <= '0;
            lat_funct3 <= '0;
            lat_lo     <= '0;
`ifdef WB_MISALIGN_CHECK_EN
            misalign_err <= 1'b0;
`endif
        end else if (rdy) begin
            wb_we <= 1'b0;
`ifdef WB_MISALIGN_CHECK_EN
            misalign_err <= load_req & misaligned;
`endif
            if (state == IDLE) begin
                if (in_valid & !in_is_load & !flush) begin
                    wb_we    <= in_we & |in_waddr;
                    wb_waddr <= in_waddr;
                    wb_wdata <= in_data;
                end
                if (load_go) begin
                    mem_req    <= 1'b1;
                    mem_addr   <= {in_data[DATA_W-1:2], 2'b00};
                    lat_we     <= in_we & |in_waddr;
                    lat_waddr  <= in_waddr;
                    lat_funct3 <= in_funct3;
                    lat_lo     <= in_data[1:0];
                end
            end else if (mem_ack) begin
                mem_req <= 1'b0;
                // a flush arriving with the ack still completes the handshake but writes nothing
                if (state == LOAD_WAIT) begin
                    wb_we    <= lat_we & !flush;
                    wb_waddr <= lat_waddr;
                    wb_wdata <= fmt_data;
                end
            end
        end
    end
endmodule
